// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM state type and default sizing for fifo_arb_ctrl
package fifo_arb_pkg;

    localparam int DEF_WIDTH_ADR  = 2;
    localparam int DEF_WIDTH_DATA = 288;
    localparam int DEF_N_REQ      = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_arb_ctrl_arbiter.sv
// rtl/fifo_arb_ctrl_arbiter.sv - write-requester arbiter (rr_arbiter), round-robin or fixed priority
// Fixed lowest-index priority when FIFO_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt
);

`ifdef FIFO_ARB_FIXED_PRIO_EN
    logic unused_clk;
    assign unused_clk = clk ^ rst;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (enable && gnt == '0 && req[i]) begin
                gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    int               gnt_idx;
    int               idx;

    // Search begins at rr_ptr and wraps, so the last winner goes to the back.
    always_comb begin
        gnt     = '0;
        gnt_idx = 0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (enable && gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= PTR_W'((gnt_idx + 1) % N_REQ);
        end
    end
`endif

endmodule

// File: rtl/fifo_arb_ctrl.sv
// rtl/fifo_arb_ctrl.sv - multi-requester write arbitration and read control for an external FIFO
// Optional FIFO_ARB_FIXED_PRIO_EN selects fixed-priority arbitration in rr_arbiter.
module fifo_arb_ctrl
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH_ADR  = DEF_WIDTH_ADR,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int N_REQ      = DEF_N_REQ
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*WIDTH_DATA-1:0] req_dt,
    output logic [N_REQ-1:0]            gnt,
    input  logic                        rd_req,
    output logic                        rd_valid,
    output logic [WIDTH_DATA-1:0]       rd_dt,
    output logic                        full,
    output logic                        empty,
    output logic [WIDTH_ADR:0]          count,
    output logic                        fifo_write_en,
    output logic [WIDTH_DATA-1:0]       fifo_write_dt,
    output logic                        fifo_read_en,
    input  logic [WIDTH_DATA-1:0]       fifo_read_dt,
    input  logic [WIDTH_ADR-1:0]        fifo_wadr,
    input  logic [WIDTH_ADR-1:0]        fifo_radr
);

    localparam logic [WIDTH_ADR:0] DEPTH = (WIDTH_ADR+1)'(1 << WIDTH_ADR);

    state_t state;
    logic   arb_en;

    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign arb_en = (state == RUN) && !rst && !full;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign fifo_write_en = |gnt;

    always_comb begin
        fifo_write_dt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                fifo_write_dt = fifo_write_dt | req_dt[i*WIDTH_DATA +: WIDTH_DATA];
            end
        end
    end

    // In SYNC the FIFO's unreset pointers are drained until they meet; that data is thrown away.
    always_comb begin
        fifo_read_en = 1'b0;
        if (!rst) begin
            if (state == SYNC) begin
                fifo_read_en = (fifo_radr != fifo_wadr);
            end else begin
                fifo_read_en = rd_req && !empty;
            end
        end
    end

    assign rd_dt = rd_valid ? fifo_read_dt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SYNC;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    rd_valid <= 1'b0;
                    if (fifo_radr == fifo_wadr) begin
                        state <= RUN;
                    end
                end
                default: begin
                    rd_valid <= fifo_read_en;
                    case ({fifo_write_en, fifo_read_en})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            endcase
        end
    end

endmodule
